// File: rtl/tone_dec_pkg.sv
// Constants shared with the piano tone generator: note periods at 50 MHz,
// period meter state encoding and default counter sizing.
package tone_dec_pkg;

   localparam int NOTE_N = 4;

   // C4, D4, E4, F4 full periods in 50 MHz cycles; must track the generator dividers
   localparam int unsigned NOTE_P [NOTE_N] = '{190840, 170068, 151515, 143266};

   localparam int CNT_W_DEF   = 19;
   localparam int TIMEOUT_DEF = 400000;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_MEASURE = 2'd2
   } meter_state_t;

endpackage

// File: rtl/tone_decoder_if.sv
// Tone decoder bus: buzzer tone into the decoder, note index and measured
// period back out to self-check / display logic.
interface tone_decoder_if #(
   parameter int CNT_W = tone_dec_pkg::CNT_W_DEF
);

   logic             tone_in;
   logic [1:0]       note_id;
   logic             note_valid;
   logic [CNT_W-1:0] period;
   logic             period_stb;

   modport master (
      input  tone_in,
      output note_id,
      output note_valid,
      output period,
      output period_stb
   );

   modport slave (
      output tone_in,
      input  note_id,
      input  note_valid,
      input  period,
      input  period_stb
   );

endinterface

// File: rtl/tone_period_meter.sv
// Rising-edge to rising-edge period meter with silence timeout.
// Define TONE_DEC_SYNC_EN to put a two-flop synchronizer in front of edge detection.
module tone_period_meter
   import tone_dec_pkg::*;
#(
   parameter int CNT_W   = CNT_W_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             tone_in,
   output logic [CNT_W-1:0] period,
   output logic             period_stb,
   output logic             timeout
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

   logic             tone_r;
   logic             tone_prev;
   logic             rise;
   logic [CNT_W-1:0] cnt;
   meter_state_t     state;

`ifdef TONE_DEC_SYNC_EN
   logic tone_p0;
   logic tone_p1;

   always_ff @(posedge clk) begin
      tone_p0 <= tone_in;
      tone_p1 <= tone_p0;
   end

   assign tone_r = tone_p1;
`else
   assign tone_r = tone_in;
`endif

   assign rise    = tone_r & ~tone_prev;
   assign timeout = (cnt == CNT_MAX);

   // tone_prev resets high so a line already high at reset release is not taken as an edge
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tone_prev  <= 1'b1;
         cnt        <= '0;
         state      <= ST_IDLE;
         period     <= '0;
         period_stb <= 1'b0;
      end else begin
         tone_prev  <= tone_r;
         period_stb <= 1'b0;

         if (rise) begin
            cnt <= CNT_W'(1);
         end else if (!timeout) begin
            cnt <= cnt + 1'b1;
         end

         if (rise && timeout) begin
            state <= ST_ARMED;
         end else if (rise) begin
            case (state)
               ST_IDLE: state <= ST_ARMED;
               default: begin
                  period     <= cnt;
                  period_stb <= 1'b1;
                  state      <= ST_MEASURE;
               end
            endcase
         end else if (timeout) begin
            state <= ST_IDLE;
         end
      end
   end

endmodule

// File: rtl/tone_decoder.sv
// Identifies which of four notes is on the buzzer line: period meter,
// tolerance window matcher and a streak filter that qualifies note_valid.
module tone_decoder
   import tone_dec_pkg::*;
#(
   parameter int          CNT_W              = CNT_W_DEF,
   parameter int          TIMEOUT            = TIMEOUT_DEF,
   parameter int          TOL_SHIFT          = 6,
   parameter int          STABLE_CNT         = 3,
   parameter int unsigned NOTE_TAB [NOTE_N]  = NOTE_P
) (
   input  logic           clk,
   input  logic           rst_n,
   tone_decoder_if.master bus
);

   localparam int            SW         = $clog2(STABLE_CNT + 1);
   localparam logic [SW-1:0] STREAK_MAX = SW'(STABLE_CNT);

   logic [CNT_W-1:0]  period;
   logic              period_stb;
   logic              timeout;
   logic [NOTE_N-1:0] hit_vec;
   logic              hit;
   logic [1:0]        hit_idx;
   logic [1:0]        cand;
   logic [SW-1:0]     streak;
   logic [SW-1:0]     streak_nxt;
   logic [1:0]        note_id;
   logic              note_valid;

   function automatic logic [CNT_W:0] abs_val(input logic signed [CNT_W:0] d);
      return d[CNT_W] ? $unsigned(-d) : $unsigned(d);
   endfunction

   function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] s);
      return (s >= STREAK_MAX) ? STREAK_MAX : s + 1'b1;
   endfunction

   tone_period_meter #(
      .CNT_W   (CNT_W),
      .TIMEOUT (TIMEOUT)
   ) u_meter (
      .clk        (clk),
      .rst_n      (rst_n),
      .tone_in    (bus.tone_in),
      .period     (period),
      .period_stb (period_stb),
      .timeout    (timeout)
   );

   // one extra bit keeps the difference signed without overflow
   for (genvar i = 0; i < NOTE_N; i++) begin : g_match
      localparam logic signed [CNT_W:0] REF = (CNT_W+1)'(NOTE_TAB[i]);
      localparam logic        [CNT_W:0] TOL = (CNT_W+1)'(NOTE_TAB[i] >> TOL_SHIFT);

      logic signed [CNT_W:0] diff;

      assign diff       = $signed({1'b0, period}) - REF;
      assign hit_vec[i] = (abs_val(diff) <= TOL);
   end

   always_comb begin
      hit     = |hit_vec;
      hit_idx = '0;
      for (int i = 0; i < NOTE_N; i++) begin
         if (hit_vec[i]) hit_idx = 2'(i);
      end
      streak_nxt = (hit_idx == cand) ? sat_inc(streak) : SW'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cand       <= '0;
         streak     <= '0;
         note_valid <= 1'b0;
         note_id    <= '0;
      end else if (timeout) begin
         streak     <= '0;
         note_valid <= 1'b0;
      end else if (period_stb) begin
         if (hit) begin
            cand       <= hit_idx;
            streak     <= streak_nxt;
            note_valid <= (streak_nxt == STREAK_MAX);
            if (streak_nxt == STREAK_MAX) note_id <= hit_idx;
         end else begin
            streak     <= '0;
            note_valid <= 1'b0;
         end
      end
   end

   assign bus.period     = period;
   assign bus.period_stb = period_stb;
   assign bus.note_id    = note_id;
   assign bus.note_valid = note_valid;

endmodule
